router_reg_hold: RTL and testbench
==================================

# router_reg_hold

Parametrised successor of the router datapath register stage. It sits between the router FSM and the three output FIFOs. It registers header and payload bytes onto `dout` and buffers bytes that arrive while the target FIFO is full in a tagged holding queue of configurable depth. It also accumulates a configurable packet checksum and flags a mismatch against the received parity byte.

## Interface
- `DATA_W`, 8: width of the data bus, the checksum and every buffer entry.
- `HOLD_DEPTH`, 4: entries in the holding queue (power of two, 2..16).
- `CHK_MODE`, 0: 0 = XOR parity; 1 = additive checksum, modulo 2^DATA_W.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `pkt_valid`  in  1  source byte valid; low in `ld_state` marks the parity byte.
- `fifo_full`  in  1  selected output FIFO is full.
- `rst_int_reg`  in  1  FSM request to clear `low_pkt_valid`.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`  in  1 each  FSM state decodes (one-hot, at most one high).
- `data_in`  in  DATA_W  byte from the source.
- `dout`  out  DATA_W  byte to the output FIFO.
- `parity_done`  out  1  parity byte has been delivered to `dout`.
- `low_pkt_valid`  out  1  parity byte has been received from the source.
- `err`  out  1  checksum mismatch for the current packet.
- `hold_count`  out  $clog2(HOLD_DEPTH)+1  current holding-queue occupancy.
- `hold_ovf`  out  1  sticky flag: a push was attempted while the queue was full.

## Operation
- Internal state:
  - `hdr`: DATA_W bits.
  - `chk`: running checksum.
  - `rxpar`: received parity byte.
  - Holding queue of HOLD_DEPTH entries, each {last, data}, with read/write pointers that wrap modulo HOLD_DEPTH.
- CHK_MODE 0 update: `chk <= chk ^ byte`.
- CHK_MODE 1 update: `chk <= chk + byte`; carry is discarded.
- `detect_add & pkt_valid`:
  - `hdr <= data_in`.
  - `chk`, `parity_done`, `err` and `hold_ovf` clear to 0.
  - Queue pointers reset; any stale queue contents are discarded.
- `lfd_state`: `dout <= hdr`; `chk` folds in `hdr`.
- `ld_state & !fifo_full`:
  - `dout <= data_in`.
  - If `pkt_valid`: `chk` folds in `data_in`.
  - Else (parity byte): `rxpar <= data_in`, `parity_done <= 1`.
- `ld_state & fifo_full`:
  - Push {!pkt_valid, data_in} into the queue; `dout` holds.
  - Payload bytes fold into `chk` at push time.
  - A parity byte loads `rxpar` at push time.
- Any `ld_state` cycle with `!pkt_valid` sets `low_pkt_valid`.
- `laf_state & !fifo_full & queue non-empty`:
  - Pop the head entry; `dout <= head.data`.
  - If `head.last`: `parity_done <= 1`.
- `laf_state` with the queue empty or `fifo_full`: `dout` holds and no pop occurs.
- Simultaneous push and pop cannot occur because the states are exclusive. The queue logic still handles the case: count unchanged, both pointers advance.
- Push while `hold_count == HOLD_DEPTH`: the byte is dropped, `hold_ovf <= 1`, and pointers are unchanged.
- `err`: registered one cycle after the edge where `parity_done` rises; value is `(chk != rxpar)`. It holds until the next `detect_add`.
- `low_pkt_valid` clears on `rst_int_reg`. If `rst_int_reg` and the set condition occur in the same cycle, set wins.
- `full_state`: no datapath action; all registers hold.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: `dout` = 0, `parity_done` = 0, `low_pkt_valid` = 0, `err` = 0, `hold_count` = 0, `hold_ovf` = 0.
  - Internal: `hdr`, `chk`, `rxpar` and the pointers = 0.
- Latency from `data_in` to `dout` is one cycle in `ld_state`.
- Latency from the header capture edge to `dout` is one cycle in `lfd_state`.
- Latency from pop to `dout` is one cycle.
- `err` is valid 1 cycle after `parity_done` and is stable thereafter.
- Reset mid-packet: the queue empties, and the next packet starts clean after `detect_add`.

## Test plan
- **XOR, clean packet.** CHK_MODE=0; header 0x0E, payload 0x11, 0x22, 0x33, parity 0x0E, `fifo_full` = 0.
  - Required: `dout` sequence 0x0E, 0x11, 0x22, 0x33, 0x0E.
  - Required: `parity_done` rises on the parity cycle and `err` = 0 one cycle later.
- **XOR, corrupted parity.** Same packet with parity 0x0F.
  - Required: `err` = 1 one cycle after `parity_done`, held until the next `detect_add`.
- **Additive checksum.** CHK_MODE=1; same header and payload, parity 0x74 (0x0E+0x11+0x22+0x33 mod 256).
  - Required: `err` = 0; with parity 0x73, `err` = 1.
- **Full FIFO mid-packet.** `fifo_full` = 1 for bytes 0x22, 0x33 and the parity byte.
  - Required: `hold_count` reaches 3.
  - Then in `laf_state` with `fifo_full` = 0: `dout` = 0x22, 0x33, 0x0E on consecutive cycles, `parity_done` rises on the 0x0E pop, `hold_count` returns to 0.
- **Overflow.** HOLD_DEPTH=4; push 5 bytes while full.
  - Required: `hold_count` = 4, `hold_ovf` = 1, and the fifth byte is never seen on `dout`.
  - The next `detect_add` clears `hold_ovf`.
- **Asynchronous reset mid-packet.** `resetn` low between clock edges during `ld_state`.
  - Required: all outputs 0 immediately.
  - A subsequent clean packet passes with `err` = 0.

Source files
------------

// File: rtl/router_reg_hold.sv
// router_reg_hold
//   Datapath register stage between the router FSM and the output FIFOs.
//   Registers header/payload bytes onto dout. Bytes that arrive while the
//   selected FIFO is full go into a tagged holding queue, which drains in
//   laf_state. The stage also accumulates a packet checksum (XOR or additive)
//   and flags a mismatch against the received parity byte.
//
// Ports
//   clock, resetn        : clock, asynchronous active-low reset
//   pkt_valid            : source byte valid; low in ld_state marks parity byte
//   fifo_full            : selected output FIFO is full
//   rst_int_reg          : clear request for low_pkt_valid
//   detect_add .. full_state : one-hot FSM state decodes
//   data_in              : byte from the source
//   dout                 : byte to the output FIFO
//   parity_done          : parity byte delivered to dout
//   low_pkt_valid        : parity byte received from the source
//   err                  : checksum mismatch for the current packet
//   hold_count           : holding-queue occupancy
//   hold_ovf             : sticky, push attempted while queue full
module router_reg_hold #(
    parameter int DATA_W     = 8,
    parameter int HOLD_DEPTH = 4,
    parameter int CHK_MODE   = 0
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          pkt_valid,
    input  logic                          fifo_full,
    input  logic                          rst_int_reg,
    input  logic                          detect_add,
    input  logic                          lfd_state,
    input  logic                          ld_state,
    input  logic                          laf_state,
    input  logic                          full_state,
    input  logic [DATA_W-1:0]             data_in,
    output logic [DATA_W-1:0]             dout,
    output logic                          parity_done,
    output logic                          low_pkt_valid,
    output logic                          err,
    output logic [$clog2(HOLD_DEPTH):0]   hold_count,
    output logic                          hold_ovf
);

    localparam int PW = $clog2(HOLD_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] chk_q, chk_d;
    logic [DATA_W-1:0] rxpar_q, rxpar_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              pd_q, pd_d;
    logic              pd_dly_q, pd_dly_d;
    logic              lpv_q, lpv_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Each entry is {last, data}; last marks the parity byte.
    logic [DATA_W:0]   mem_q [HOLD_DEPTH];
    logic [DATA_W:0]   head;

    logic start, act, push, pop, q_full, push_ok;

    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        if (CHK_MODE == 1) return a + b;
        else               return a ^ b;
    endfunction

    always_comb begin
        start   = detect_add & pkt_valid;
        // full_state freezes the datapath; the decodes are one-hot so this
        // gate never masks another state's action.
        act     = !full_state & !start;
        q_full  = (cnt_q == CW'(HOLD_DEPTH));
        push    = act & ld_state & fifo_full;
        pop     = act & laf_state & !fifo_full & (cnt_q != '0);
        push_ok = push & !q_full;
        head    = mem_q[rd_q];

        hdr_d    = hdr_q;
        chk_d    = chk_q;
        rxpar_d  = rxpar_q;
        dout_d   = dout_q;
        pd_d     = pd_q;
        ovf_d    = ovf_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        pd_dly_d = pd_q;

        if (start) begin
            hdr_d = data_in;
            chk_d = '0;
            pd_d  = 1'b0;
            ovf_d = 1'b0;
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else if (act) begin
            if (lfd_state) begin
                dout_d = hdr_q;
                chk_d  = fold(chk_q, hdr_q);
            end
            if (ld_state && !fifo_full) begin
                dout_d = data_in;
                if (pkt_valid) chk_d = fold(chk_q, data_in);
                else begin
                    rxpar_d = data_in;
                    pd_d    = 1'b1;
                end
            end
            if (push) begin
                if (q_full) ovf_d = 1'b1;
                else begin
                    wr_d = wr_q + 1'b1;
                    if (pkt_valid) chk_d = fold(chk_q, data_in);
                    else           rxpar_d = data_in;
                end
            end
            if (pop) begin
                rd_d   = rd_q + 1'b1;
                dout_d = head[DATA_W-1:0];
                if (head[DATA_W]) pd_d = 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        // err samples the checksum on the edge after parity_done rises.
        err_d = err_q;
        if (start)                err_d = 1'b0;
        else if (pd_q && !pd_dly_q) err_d = (chk_q != rxpar_q);

        // A same-cycle set beats the clear request.
        lpv_d = lpv_q;
        if (ld_state && !pkt_valid) lpv_d = 1'b1;
        else if (rst_int_reg)       lpv_d = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_q    <= '0;
            chk_q    <= '0;
            rxpar_q  <= '0;
            dout_q   <= '0;
            pd_q     <= 1'b0;
            pd_dly_q <= 1'b0;
            lpv_q    <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            hdr_q    <= hdr_d;
            chk_q    <= chk_d;
            rxpar_q  <= rxpar_d;
            dout_q   <= dout_d;
            pd_q     <= pd_d;
            pd_dly_q <= pd_dly_d;
            lpv_q    <= lpv_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_q] <= {~pkt_valid, data_in};
    end

    assign dout          = dout_q;
    assign parity_done   = pd_q;
    assign low_pkt_valid = lpv_q;
    assign err           = err_q;
    assign hold_count    = cnt_q;
    assign hold_ovf      = ovf_q;

endmodule

// File: tb/tb_router_reg_hold.sv
module tb_router_reg_hold;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn, pkt_valid, fifo_full, rst_int_reg;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic [7:0] data_in;
    logic [7:0] dout_x, dout_a;
    logic       pd_x, pd_a, lpv_x, lpv_a, err_x, err_a, ovf_x, ovf_a;
    logic [2:0] cnt_x, cnt_a;

    int checks   = 0;
    int failures = 0;

    router_reg_hold #(.DATA_W(8), .HOLD_DEPTH(4), .CHK_MODE(0)) u_dut_x (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .data_in(data_in), .dout(dout_x), .parity_done(pd_x), .low_pkt_valid(lpv_x),
        .err(err_x), .hold_count(cnt_x), .hold_ovf(ovf_x)
    );

    router_reg_hold #(.DATA_W(8), .HOLD_DEPTH(4), .CHK_MODE(1)) u_dut_a (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .data_in(data_in), .dout(dout_a), .parity_done(pd_a), .low_pkt_valid(lpv_a),
        .err(err_a), .hold_count(cnt_a), .hold_ovf(ovf_a)
    );

    task automatic clr();
        pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; detect_add = 0;
        lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Full packet with FIFO never full; checks dout per byte and err afterwards.
    task automatic run_packet(input logic [7:0] h, input logic [7:0] p0,
                              input logic [7:0] p1, input logic [7:0] p2,
                              input logic [7:0] par, input logic ex_err_x,
                              input logic ex_err_a, input string nm);
        logic [7:0] seq [5];
        seq = '{h, p0, p1, p2, par};
        clr(); detect_add = 1; pkt_valid = 1; data_in = h; tick();
        clr(); lfd_state = 1; tick();
        checks++;
        if (dout_x !== h) begin
            failures++; $display("FAIL %s hdr_dout got=%h exp=%h", nm, dout_x, h);
        end
        for (int i = 1; i < 5; i++) begin
            clr(); ld_state = 1; pkt_valid = (i < 4); data_in = seq[i];
            rst_int_reg = (i == 4);
            tick();
            checks++;
            if (dout_x !== seq[i] || dout_a !== seq[i]) begin
                failures++; $display("FAIL %s dout[%0d] got=%h/%h exp=%h", nm, i, dout_x, dout_a, seq[i]);
            end
            checks++;
            if (pd_x !== (i == 4)) begin
                failures++; $display("FAIL %s parity_done[%0d] got=%b exp=%b", nm, i, pd_x, (i == 4));
            end
        end
        checks++;
        if (lpv_x !== 1'b1 || err_x !== 1'b0) begin
            failures++; $display("FAIL %s lpv_set_wins/err_early got=%b/%b exp=1/0", nm, lpv_x, err_x);
        end
        clr(); rst_int_reg = 1; tick();
        checks++;
        if (err_x !== ex_err_x || err_a !== ex_err_a) begin
            failures++; $display("FAIL %s err got=%b/%b exp=%b/%b", nm, err_x, err_a, ex_err_x, ex_err_a);
        end
        checks++;
        if (lpv_x !== 1'b0) begin
            failures++; $display("FAIL %s lpv_clear got=%b exp=0", nm, lpv_x);
        end
    endtask

    task automatic test_reset();
        resetn = 1; clr(); data_in = 8'h00;
        #2 resetn = 0;
        #1;
        checks++;
        if ({dout_x, pd_x, lpv_x, err_x, cnt_x, ovf_x, dout_a, pd_a, lpv_a, err_a, cnt_a, ovf_a} !== 30'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0",
                {dout_x, pd_x, lpv_x, err_x, cnt_x, ovf_x, dout_a, pd_a, lpv_a, err_a, cnt_a, ovf_a});
        end
        repeat (2) @(posedge clock);
        @(negedge clock) resetn = 1;
        tick();
    endtask

    task automatic test_xor_clean();
        // XOR of 0E,11,22,33 = 0E; additive sum = 74 so the CHK_MODE=1 copy flags.
        run_packet(8'h0E, 8'h11, 8'h22, 8'h33, 8'h0E, 1'b0, 1'b1, "xor_clean");
        clr(); full_state = 1; data_in = 8'hFF; tick();
        checks++;
        if (dout_x !== 8'h0E || pd_x !== 1'b1) begin
            failures++; $display("FAIL full_state_hold got=%h/%b exp=0e/1", dout_x, pd_x);
        end
    endtask

    task automatic test_xor_corrupt();
        run_packet(8'h0E, 8'h11, 8'h22, 8'h33, 8'h0F, 1'b1, 1'b1, "xor_corrupt");
        clr(); repeat (3) tick();
        checks++;
        if (err_x !== 1'b1) begin
            failures++; $display("FAIL err_held got=%b exp=1", err_x);
        end
        clr(); detect_add = 1; pkt_valid = 1; data_in = 8'h0E; tick();
        checks++;
        if (err_x !== 1'b0 || pd_x !== 1'b0) begin
            failures++; $display("FAIL detect_clears got=%b/%b exp=0/0", err_x, pd_x);
        end
    endtask

    task automatic test_additive();
        run_packet(8'h0E, 8'h11, 8'h22, 8'h33, 8'h74, 1'b1, 1'b0, "add_clean");
        run_packet(8'h0E, 8'h11, 8'h22, 8'h33, 8'h73, 1'b1, 1'b1, "add_corrupt");
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_pop [3];
        exp_pop = '{8'h22, 8'h33, 8'h0E};
        clr(); detect_add = 1; pkt_valid = 1; data_in = 8'h0E; tick();
        clr(); lfd_state = 1; tick();
        clr(); ld_state = 1; pkt_valid = 1; data_in = 8'h11; tick();
        clr(); ld_state = 1; fifo_full = 1; pkt_valid = 1; data_in = 8'h22; tick();
        clr(); ld_state = 1; fifo_full = 1; pkt_valid = 1; data_in = 8'h33; tick();
        clr(); ld_state = 1; fifo_full = 1; pkt_valid = 0; data_in = 8'h0E; tick();
        checks++;
        if (cnt_x !== 3'd3 || dout_x !== 8'h11 || pd_x !== 1'b0 || lpv_x !== 1'b1) begin
            failures++; $display("FAIL full_push got cnt=%0d dout=%h pd=%b lpv=%b exp 3/11/0/1", cnt_x, dout_x, pd_x, lpv_x);
        end
        clr(); laf_state = 1; fifo_full = 1; tick();
        checks++;
        if (cnt_x !== 3'd3 || dout_x !== 8'h11) begin
            failures++; $display("FAIL laf_full_nopop got cnt=%0d dout=%h exp 3/11", cnt_x, dout_x);
        end
        for (int i = 0; i < 3; i++) begin
            clr(); laf_state = 1; tick();
            checks++;
            if (dout_x !== exp_pop[i] || cnt_x !== 3'(2 - i) || pd_x !== (i == 2)) begin
                failures++; $display("FAIL pop[%0d] got dout=%h cnt=%0d pd=%b exp %h/%0d/%b",
                    i, dout_x, cnt_x, pd_x, exp_pop[i], 2 - i, (i == 2));
            end
        end
        clr(); laf_state = 1; tick();
        checks++;
        if (dout_x !== 8'h0E || err_x !== 1'b0 || err_a !== 1'b1) begin
            failures++; $display("FAIL drained_err got dout=%h err=%b/%b exp 0e/0/1", dout_x, err_x, err_a);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        clr(); detect_add = 1; pkt_valid = 1; data_in = 8'h55; tick();
        clr(); lfd_state = 1; tick();
        for (int i = 0; i < 5; i++) begin
            b = 8'hA1 + 8'(i);
            clr(); ld_state = 1; fifo_full = 1; pkt_valid = 1; data_in = b; tick();
            checks++;
            if (cnt_x !== ((i < 4) ? 3'(i + 1) : 3'd4) || ovf_x !== (i == 4) || dout_x !== 8'h55) begin
                failures++; $display("FAIL ovf_push[%0d] got cnt=%0d ovf=%b dout=%h", i, cnt_x, ovf_x, dout_x);
            end
        end
        for (int i = 0; i < 4; i++) begin
            b = 8'hA1 + 8'(i);
            clr(); laf_state = 1; tick();
            checks++;
            if (dout_x !== b) begin
                failures++; $display("FAIL ovf_pop[%0d] got=%h exp=%h", i, dout_x, b);
            end
        end
        clr(); laf_state = 1; tick();
        checks++;
        if (dout_x !== 8'hA4 || cnt_x !== 3'd0 || ovf_x !== 1'b1) begin
            failures++; $display("FAIL ovf_no_fifth got dout=%h cnt=%0d ovf=%b exp a4/0/1", dout_x, cnt_x, ovf_x);
        end
        clr(); detect_add = 1; pkt_valid = 1; data_in = 8'h0E; tick();
        checks++;
        if (ovf_x !== 1'b0) begin
            failures++; $display("FAIL ovf_clear got=%b exp=0", ovf_x);
        end
    endtask

    task automatic test_async_reset();
        clr(); detect_add = 1; pkt_valid = 1; data_in = 8'h0E; tick();
        clr(); lfd_state = 1; tick();
        clr(); ld_state = 1; pkt_valid = 1; data_in = 8'h11; tick();
        clr(); ld_state = 1; fifo_full = 1; pkt_valid = 1; data_in = 8'h22; tick();
        clr(); ld_state = 1; fifo_full = 1; pkt_valid = 0; data_in = 8'h0E; tick();
        checks++;
        if (cnt_x !== 3'd2 || lpv_x !== 1'b1 || dout_x !== 8'h11) begin
            failures++; $display("FAIL pre_reset got cnt=%0d lpv=%b dout=%h exp 2/1/11", cnt_x, lpv_x, dout_x);
        end
        clr();
        #2 resetn = 0;
        #1;
        checks++;
        if ({dout_x, pd_x, lpv_x, err_x, cnt_x, ovf_x} !== 15'd0) begin
            failures++; $display("FAIL async_reset got=%h exp=0", {dout_x, pd_x, lpv_x, err_x, cnt_x, ovf_x});
        end
        @(negedge clock) resetn = 1;
        tick();
        run_packet(8'h0E, 8'h11, 8'h22, 8'h33, 8'h0E, 1'b0, 1'b1, "post_reset");
        checks++;
        if (cnt_x !== 3'd0) begin
            failures++; $display("FAIL post_reset_empty got=%0d exp=0", cnt_x);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_xor_clean();
        test_xor_corrupt();
        test_additive();
        test_fifo_full();
        test_overflow();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
